// File: rtl/core_pkg.sv
// Shared state encoding, default widths and word-count helper for the matrix-multiplier compute cores.
package core_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_ACC_W  = 16;
  localparam int unsigned DEF_LEN_W  = 8;
  localparam int unsigned DEF_WORDS  = DEF_ACC_W / DEF_DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_WT_A = 3'd2,
    ST_RD_B = 3'd3,
    ST_WT_B = 3'd4,
    ST_MAC  = 3'd5,
    ST_WR   = 3'd6,
    ST_DONE = 3'd7
  } state_t;

  // Number of DRAM words that make up one accumulator.
  function automatic int unsigned words(input int unsigned acc_w, input int unsigned data_w);
    return acc_w / data_w;
  endfunction

endpackage

// File: rtl/dot_product_core_if.sv
// Command and DRAM-bus bundle of one dot-product core; master = core side, slave = system side.
interface dot_product_core_if
  import core_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
);

  logic              i_start;
  logic [LEN_W-1:0]  i_len;
  logic [ADDR_W-1:0] i_a_base;
  logic [ADDR_W-1:0] i_a_stride;
  logic [ADDR_W-1:0] i_b_base;
  logic [ADDR_W-1:0] i_b_stride;
  logic [ADDR_W-1:0] i_c_addr;
  logic              i_dram_gnt;
  logic [DATA_W-1:0] i_dram_in;
  logic [ADDR_W-1:0] o_dram_addr;
  logic              o_dram_read;
  logic              o_dram_write;
  logic [DATA_W-1:0] o_dram_out;
  logic              o_busy;
  logic              o_done;
  logic              o_ovf;
  logic [7:0]        o_core_id;

  modport master (
    input  i_start, i_len, i_a_base, i_a_stride, i_b_base, i_b_stride, i_c_addr,
    input  i_dram_gnt, i_dram_in,
    output o_dram_addr, o_dram_read, o_dram_write, o_dram_out,
    output o_busy, o_done, o_ovf, o_core_id
  );

  modport slave (
    output i_start, i_len, i_a_base, i_a_stride, i_b_base, i_b_stride, i_c_addr,
    output i_dram_gnt, i_dram_in,
    input  o_dram_addr, o_dram_read, o_dram_write, o_dram_out,
    input  o_busy, o_done, o_ovf, o_core_id
  );

endinterface

// File: rtl/mac_unit.sv
// Combinational multiply-accumulate step: next accumulator value and overflow flag.
module mac_unit
  import core_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter bit          SAT    = 1'b0
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc_next_c,
  output logic              ovf_c
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned EXT_W  = (PROD_W > ACC_W) ? PROD_W : ACC_W;

  logic [PROD_W-1:0] prod;
  logic [EXT_W-1:0]  prod_ext;
  logic [ACC_W:0]    sum;
  logic              trunc_ovf;

  // Product bits above ACC_W are lost on truncation and count as overflow.
  always_comb begin
    prod       = PROD_W'(a) * PROD_W'(b);
    prod_ext   = EXT_W'(prod);
    trunc_ovf  = |(prod_ext >> ACC_W);
    sum        = (ACC_W + 1)'(acc) + (ACC_W + 1)'(prod_ext[ACC_W-1:0]);
    ovf_c      = sum[ACC_W] | trunc_ovf;
    acc_next_c = sum[ACC_W-1:0];
    if (SAT && ovf_c) begin
      acc_next_c = '1;
    end
  end

endmodule

// File: rtl/dot_product_core.sv
// One compute core: reads strided A row / B column from shared DRAM, accumulates, writes C back.
module dot_product_core
  import core_pkg::*;
#(
  parameter logic [7:0]  CORE_ID = 8'd1,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned ACC_W   = DEF_ACC_W,
  parameter int unsigned LEN_W   = DEF_LEN_W,
  parameter bit          SAT     = 1'b0
) (
  input logic                i_clk,
  input logic                i_rst,
  dot_product_core_if.master bus
);

  localparam int unsigned WORDS  = words(ACC_W, DATA_W);
  localparam int unsigned WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t            state;
  logic [ADDR_W-1:0] a_addr, b_addr, a_stride, b_stride, c_addr, dram_addr;
  logic [ADDR_W-1:0] a_next, b_next;
  logic [LEN_W-1:0]  len_cnt;
  logic [DATA_W-1:0] a_reg, b_reg, dram_out;
  logic [ACC_W-1:0]  acc, acc_next, acc_shr;
  logic [WIDX_W-1:0] widx;
  logic              mac_ovf, dram_read, dram_write, busy, done, ovf;

  mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SAT(SAT)) u_mac (
    .acc        (acc),
    .a          (a_reg),
    .b          (b_reg),
    .acc_next_c (acc_next),
    .ovf_c      (mac_ovf)
  );

  assign a_next  = a_addr + a_stride;
  assign b_next  = b_addr + b_stride;
  assign acc_shr = acc >> DATA_W;

  // Sequencer; during WR the accumulator doubles as the write shift register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      a_addr     <= '0;
      b_addr     <= '0;
      a_stride   <= '0;
      b_stride   <= '0;
      c_addr     <= '0;
      len_cnt    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      acc        <= '0;
      widx       <= '0;
      dram_addr  <= '0;
      dram_out   <= '0;
      dram_read  <= 1'b0;
      dram_write <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (bus.i_start) begin
            a_addr   <= bus.i_a_base;
            b_addr   <= bus.i_b_base;
            a_stride <= bus.i_a_stride;
            b_stride <= bus.i_b_stride;
            c_addr   <= bus.i_c_addr;
            len_cnt  <= bus.i_len;
            acc      <= '0;
            ovf      <= 1'b0;
            widx     <= '0;
            busy     <= 1'b1;
            if (bus.i_len == '0) begin
              state      <= ST_WR;
              dram_addr  <= bus.i_c_addr;
              dram_out   <= '0;
              dram_write <= 1'b1;
            end else begin
              state     <= ST_RD_A;
              dram_addr <= bus.i_a_base;
              dram_read <= 1'b1;
            end
          end
        end
        ST_RD_A: begin
          if (bus.i_dram_gnt) begin
            state     <= ST_WT_A;
            dram_read <= 1'b0;
          end
        end
        ST_WT_A: begin
          a_reg     <= bus.i_dram_in;
          state     <= ST_RD_B;
          dram_addr <= b_addr;
          dram_read <= 1'b1;
        end
        ST_RD_B: begin
          if (bus.i_dram_gnt) begin
            state     <= ST_WT_B;
            dram_read <= 1'b0;
          end
        end
        ST_WT_B: begin
          b_reg <= bus.i_dram_in;
          state <= ST_MAC;
        end
        ST_MAC: begin
          acc     <= acc_next;
          ovf     <= ovf | mac_ovf;
          a_addr  <= a_next;
          b_addr  <= b_next;
          len_cnt <= len_cnt - LEN_W'(1);
          if (len_cnt == LEN_W'(1)) begin
            state      <= ST_WR;
            dram_addr  <= c_addr;
            dram_out   <= acc_next[DATA_W-1:0];
            dram_write <= 1'b1;
          end else begin
            state     <= ST_RD_A;
            dram_addr <= a_next;
            dram_read <= 1'b1;
          end
        end
        ST_WR: begin
          if (bus.i_dram_gnt) begin
            if (widx == WIDX_W'(WORDS - 1)) begin
              state      <= ST_DONE;
              dram_write <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              widx      <= widx + WIDX_W'(1);
              dram_addr <= dram_addr + ADDR_W'(1);
              dram_out  <= acc_shr[DATA_W-1:0];
              acc       <= acc_shr;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_dram_addr  = dram_addr;
  assign bus.o_dram_read  = dram_read;
  assign bus.o_dram_write = dram_write;
  assign bus.o_dram_out   = dram_out;
  assign bus.o_busy       = busy;
  assign bus.o_done       = done;
  assign bus.o_ovf        = ovf;
  assign bus.o_core_id    = CORE_ID;

endmodule

// File: tb/tb_dot_product_core.sv
// Bench for dot_product_core: DRAM responder with programmable grant delay, table of vectors, reset abort.
module tb_dot_product_core;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 16;
  localparam int unsigned LW    = 8;
  localparam int unsigned WORDS = 2;
  localparam int          NVEC  = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    len = '0;
  logic [15:0]   a_base = '0, a_stride = '0, b_base = '0, b_stride = '0, c_addr = '0;
  logic          gnt = 1'b0;
  logic [7:0]    din = '0;
  bit            sel = 1'b0;

  dot_product_core_if #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) bus0 ();
  dot_product_core_if #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) bus1 ();

  dot_product_core #(.SAT(1'b0)) dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
  dot_product_core #(.SAT(1'b1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));

  // Operands go to both cores; start and grant only to the selected one.
  assign bus0.i_start    = start & ~sel;
  assign bus1.i_start    = start & sel;
  assign bus0.i_dram_gnt = gnt & ~sel;
  assign bus1.i_dram_gnt = gnt & sel;
  assign bus0.i_len = len;           assign bus1.i_len = len;
  assign bus0.i_a_base = a_base;     assign bus1.i_a_base = a_base;
  assign bus0.i_a_stride = a_stride; assign bus1.i_a_stride = a_stride;
  assign bus0.i_b_base = b_base;     assign bus1.i_b_base = b_base;
  assign bus0.i_b_stride = b_stride; assign bus1.i_b_stride = b_stride;
  assign bus0.i_c_addr = c_addr;     assign bus1.i_c_addr = c_addr;
  assign bus0.i_dram_in = din;       assign bus1.i_dram_in = din;

  logic        r_read, r_write, r_busy, r_done, r_ovf;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  always_comb begin
    r_read  = sel ? bus1.o_dram_read  : bus0.o_dram_read;
    r_write = sel ? bus1.o_dram_write : bus0.o_dram_write;
    r_busy  = sel ? bus1.o_busy       : bus0.o_busy;
    r_done  = sel ? bus1.o_done       : bus0.o_done;
    r_ovf   = sel ? bus1.o_ovf        : bus0.o_ovf;
    r_addr  = sel ? bus1.o_dram_addr  : bus0.o_dram_addr;
    r_wdata = sel ? bus1.o_dram_out   : bus0.o_dram_out;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [7:0]  mem [0:65535];
  int          gnt_delay = 0;
  bit          noise = 1'b0;
  int          wait_cnt = 0;
  logic [23:0] hold_req = '0;
  bit          rd_data_due = 1'b0;
  logic [15:0] rd_addr_q = '0;
  logic [15:0] read_log [$];
  logic [15:0] wr_addr_log [$];
  logic [7:0]  wr_data_log [$];

  // DRAM model: withholds grant gnt_delay cycles per request, returns data the cycle after a read grant.
  always @(negedge clk) begin
    din = rd_data_due ? mem[rd_addr_q] : 8'($urandom);
    rd_data_due = 1'b0;
    gnt = 1'b0;
    if (rst) begin
      wait_cnt = 0;
    end else if (r_read || r_write) begin
      chk("rd_wr_exclusive", {31'b0, r_read & r_write}, 32'd0);
      if (wait_cnt > 0) chk("req_hold", {8'h0, r_addr, r_write ? r_wdata : 8'h0}, {8'h0, hold_req});
      hold_req = {r_addr, r_write ? r_wdata : 8'h0};
      if (wait_cnt >= gnt_delay) begin
        gnt = 1'b1;
        wait_cnt = 0;
        if (r_read) begin
          rd_data_due = 1'b1;
          rd_addr_q   = r_addr;
          read_log.push_back(r_addr);
        end else begin
          mem[r_addr] = r_wdata;
          wr_addr_log.push_back(r_addr);
          wr_data_log.push_back(r_wdata);
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      if (noise) gnt = 1'($urandom);
    end
  end

  typedef struct {
    bit          sat;
    logic [7:0]  len;
    logic [15:0] a_base, a_stride, b_base, b_stride, c_addr;
    int          delay;
    bit          noise;
    bit          mid_start;
    logic [15:0] exp_res;
    bit          exp_ovf;
    int          exp_lat;
  } vec_t;

  vec_t vecs [NVEC];
  int   t_start = 0;

  function automatic vec_t mk(input bit s, input logic [7:0] l, input logic [15:0] ab, as_,
                              input logic [15:0] bb, bs, ca, input int d, input bit nz, input bit ms);
    vec_t v;
    v.sat = s; v.len = l; v.a_base = ab; v.a_stride = as_; v.b_base = bb; v.b_stride = bs;
    v.c_addr = ca; v.delay = d; v.noise = nz; v.mid_start = ms;
    v.exp_res = '0; v.exp_ovf = 1'b0;
    v.exp_lat = 5 * int'(l) + int'(WORDS) + 2 + d * (2 * int'(l) + int'(WORDS));
    return v;
  endfunction

  // Reference: plain sum of products, overflow when the running total leaves 16 bits.
  task automatic model(inout vec_t v);
    longint      acc = 0;
    logic [15:0] aa = v.a_base;
    logic [15:0] bb = v.b_base;
    v.exp_ovf = 1'b0;
    for (int i = 0; i < int'(v.len); i++) begin
      acc = acc + longint'(mem[aa]) * longint'(mem[bb]);
      if (acc > 65535) begin
        v.exp_ovf = 1'b1;
        acc = v.sat ? 65535 : acc - 65536;
      end
      aa = aa + v.a_stride;
      bb = bb + v.b_stride;
    end
    v.exp_res = 16'(acc);
  endtask

  task automatic launch(input vec_t v, input string tag);
    @(negedge clk);
    sel = v.sat; gnt_delay = v.delay; noise = v.noise;
    len = v.len; a_base = v.a_base; a_stride = v.a_stride;
    b_base = v.b_base; b_stride = v.b_stride; c_addr = v.c_addr;
    read_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
    start = 1'b1;
    t_start = cyc;
    @(negedge clk);
    start = 1'b0;
    len = 8'($urandom); a_base = 16'($urandom); a_stride = 16'($urandom);
    b_base = 16'($urandom); b_stride = 16'($urandom); c_addr = 16'($urandom);
    chk({tag, "_busy_rise"}, {31'b0, r_busy}, 32'd1);
  endtask

  task automatic finish(input vec_t v, input string tag);
    int          k = 0;
    int          bad = 0;
    logic [15:0] res = '0;
    logic [15:0] exp_rd [$];
    logic [15:0] aa = v.a_base;
    logic [15:0] bb = v.b_base;
    while (!r_done && k < 3000) begin
      if (v.mid_start) start = (k == 3);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (!r_done) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: o_done not seen within %0d cycles", tag, k);
      return;
    end
    chk({tag, "_latency"}, 32'(cyc - t_start + 1), 32'(v.exp_lat));
    chk({tag, "_busy_at_done"}, {31'b0, r_busy}, 32'd0);
    chk({tag, "_ovf"}, {31'b0, r_ovf}, {31'b0, v.exp_ovf});
    chk({tag, "_wr_count"}, 32'(wr_addr_log.size()), WORDS);
    for (int i = 0; i < wr_addr_log.size(); i++) begin
      if (wr_addr_log[i] !== 16'(v.c_addr + 16'(i))) bad++;
      if (i < 2) res = res | (16'(wr_data_log[i]) << (8 * i));
    end
    chk({tag, "_wr_addr_errs"}, 32'(bad), 32'd0);
    chk({tag, "_result"}, {16'h0, res}, {16'h0, v.exp_res});
    for (int i = 0; i < int'(v.len); i++) begin
      exp_rd.push_back(aa);
      exp_rd.push_back(bb);
      aa = aa + v.a_stride;
      bb = bb + v.b_stride;
    end
    bad = 0;
    for (int i = 0; i < read_log.size() && i < exp_rd.size(); i++)
      if (read_log[i] !== exp_rd[i]) bad++;
    chk({tag, "_rd_count"}, 32'(read_log.size()), 32'(exp_rd.size()));
    chk({tag, "_rd_addr_errs"}, 32'(bad), 32'd0);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, {31'b0, r_done}, 32'd0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   k;
    vec_t vr;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0100] = 8'd1; mem[16'h0101] = 8'd2; mem[16'h0102] = 8'd3;
    mem[16'h0200] = 8'd4; mem[16'h0203] = 8'd5; mem[16'h0206] = 8'd6;
    mem[16'h0300] = 8'd255; mem[16'h0301] = 8'd255;
    mem[16'hFFFF] = 8'd7; mem[16'h0000] = 8'd9;
    mem[16'h0500] = 8'd2; mem[16'h0501] = 8'd3;

    vecs[0] = mk(1'b0, 8'd3, 16'h0100, 16'd1, 16'h0200, 16'd3, 16'h9000, 0, 1'b0, 1'b0);
    vecs[0].exp_res = 16'h0020; vecs[0].exp_ovf = 1'b0; vecs[0].exp_lat = 19;
    vecs[1] = mk(1'b0, 8'd3, 16'h0100, 16'd1, 16'h0200, 16'd3, 16'h9010, 5, 1'b0, 1'b0);
    vecs[1].exp_res = 16'h0020; vecs[1].exp_ovf = 1'b0; vecs[1].exp_lat = 19 + 5 * 8;
    vecs[2] = mk(1'b0, 8'd2, 16'h0300, 16'd1, 16'h0300, 16'd1, 16'h9020, 0, 1'b0, 1'b0);
    vecs[2].exp_res = 16'hFC02; vecs[2].exp_ovf = 1'b1; vecs[2].exp_lat = 14;
    vecs[3] = mk(1'b1, 8'd2, 16'h0300, 16'd1, 16'h0300, 16'd1, 16'h9030, 0, 1'b0, 1'b0);
    vecs[3].exp_res = 16'hFFFF; vecs[3].exp_ovf = 1'b1; vecs[3].exp_lat = 14;
    vecs[4] = mk(1'b0, 8'd0, 16'h0100, 16'd1, 16'h0200, 16'd1, 16'h9040, 0, 1'b0, 1'b0);
    vecs[4].exp_res = 16'h0000; vecs[4].exp_ovf = 1'b0; vecs[4].exp_lat = 4;
    vecs[5] = mk(1'b0, 8'd2, 16'hFFFF, 16'd1, 16'h0500, 16'd1, 16'h9050, 0, 1'b0, 1'b1);
    vecs[5].exp_res = 16'h0029; vecs[5].exp_ovf = 1'b0; vecs[5].exp_lat = 14;
    for (int i = 6; i < NVEC; i++) begin
      vecs[i] = mk(1'($urandom), 8'($urandom_range(1, 12)), 16'($urandom_range(0, 16'h5FFF)),
                   16'($urandom_range(0, 16'h1FF)), 16'($urandom_range(0, 16'h5FFF)),
                   16'($urandom_range(0, 16'h1FF)), 16'(16'hA000 + 16'(i * 4)),
                   int'($urandom_range(0, 2)), 1'b1, 1'b0);
      model(vecs[i]);
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy0",  {31'b0, bus0.o_busy}, 32'd0);
    chk("rst_done0",  {31'b0, bus0.o_done}, 32'd0);
    chk("rst_ovf0",   {31'b0, bus0.o_ovf}, 32'd0);
    chk("rst_read0",  {31'b0, bus0.o_dram_read}, 32'd0);
    chk("rst_write0", {31'b0, bus0.o_dram_write}, 32'd0);
    chk("rst_addr0",  {16'h0, bus0.o_dram_addr}, 32'd0);
    chk("rst_out0",   {24'h0, bus0.o_dram_out}, 32'd0);
    chk("rst_busy1",  {31'b0, bus1.o_busy}, 32'd0);
    chk("core_id0",   {24'h0, bus0.o_core_id}, 32'd1);
    chk("core_id1",   {24'h0, bus1.o_core_id}, 32'd1);

    for (int i = 0; i < NVEC; i++) begin
      launch(vecs[i], $sformatf("v%0d", i));
      finish(vecs[i], $sformatf("v%0d", i));
    end

    // Asynchronous reset while the core waits on the B read.
    vr = vecs[0];
    vr.delay = 3;
    launch(vr, "rst_abort");
    k = 0;
    while (!(r_read && r_addr == vr.b_base && read_log.size() == 1) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reached_rd_b", {31'b0, r_read}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_read", {31'b0, r_read}, 32'd0);
    chk("rst_async_busy", {31'b0, r_busy}, 32'd0);
    chk("rst_async_addr", {16'h0, r_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(vecs[0], "post_rst");
    finish(vecs[0], "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
